seq_datapath: RTL and testbench

//  Parametrised, self-sequenced successor to the single-cycle-controlled datapath.

---
 rtl/seq_datapath_pkg.sv | 45 ++++
 rtl/dp_alu_shift.sv | 58 +++++
 rtl/seq_datapath.sv | 147 ++++++++++++++
 tb/tb_seq_datapath.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_datapath_pkg.sv
// Shared types for the self-sequenced datapath: op encodings, FSM states, latched op controls.
// Pure type definitions; no logic, no latency.
package seq_datapath_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_MVN = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      SRC_MDATA = 2'b00,
      SRC_IMM   = 2'b01,
      SRC_PC    = 2'b10,
      SRC_C     = 2'b11
   } src_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_e;

   // Width-independent control fields captured at op acceptance
   typedef struct packed {
      alu_op_e alu_op;
      shift_e  shift;
      src_e    src;
      logic    zero_a;
      logic    use_imm;
      logic    set_flags;
      logic    wr_en;
   } op_ctrl_t;

endpackage

// File: rtl/dp_alu_shift.sv
// Combinational B-shifter, operand muxes, ALU and {V,N,Z} flag generation.
// Zero latency; no flow control.
module dp_alu_shift
   import seq_datapath_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_val,
   input  logic [WIDTH-1:0] b_val,
   input  logic [WIDTH-1:0] imm,
   input  logic             zero_a,
   input  logic             use_imm,
   input  shift_e           shift,
   input  alu_op_e          alu_op,
   output logic [WIDTH-1:0] c_next,
   output logic [2:0]       flags
);

   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             v_flag;

   always_comb begin
      b_sh = b_val;
      case (shift)
         SH_LSL1: b_sh = {b_val[WIDTH-2:0], 1'b0};
         SH_LSR1: b_sh = {1'b0, b_val[WIDTH-1:1]};
         SH_ASR1: b_sh = {b_val[WIDTH-1], b_val[WIDTH-1:1]};
         default: b_sh = b_val;
      endcase

      ain  = zero_a ? '0 : a_val;
      bin  = use_imm ? imm : b_sh;
      sum  = ain + bin;
      diff = ain - bin;

      c_next = sum;
      v_flag = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            c_next = sum;
            v_flag = (ain[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]);
         end
         ALU_SUB: begin
            c_next = diff;
            v_flag = (ain[WIDTH-1] != bin[WIDTH-1]) && (diff[WIDTH-1] != ain[WIDTH-1]);
         end
         ALU_AND: c_next = ain & bin;
         default: c_next = ~bin;
      endcase

      flags = {v_flag, c_next[WIDTH-1], (c_next == '0)};
   end

endmodule

// File: rtl/seq_datapath.sv
// Register file + A/B/C/status datapath sequenced IDLE->RD_A->RD_B->EXEC->WB (ALU) or IDLE->WB.
// done in 4th cycle (ALU) / 1st cycle (other); op_ready low from acceptance until back in IDLE.
module seq_datapath
   import seq_datapath_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int NREGS = 8,
   localparam int RSEL  = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [1:0]       alu_op,
   input  logic [1:0]       shift,
   input  logic [1:0]       src,
   input  logic [RSEL-1:0]  rn,
   input  logic [RSEL-1:0]  rm,
   input  logic [RSEL-1:0]  rd,
   input  logic             zero_a,
   input  logic             use_imm,
   input  logic             set_flags,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] mdata,
   input  logic [7:0]       pc,
   input  logic [RSEL-1:0]  dbg_rnum,
   output logic [WIDTH-1:0] dbg_rdata,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       status,
   output logic             done
);

   state_e           state_q, state_d;
   op_ctrl_t         op_q, op_d;
   logic [RSEL-1:0]  rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [2:0]       status_q, status_d;
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [WIDTH-1:0] alu_c;
   logic [2:0]       alu_flags;
   logic [WIDTH-1:0] wb_data;

   dp_alu_shift #(.WIDTH(WIDTH)) u_alu (
      .a_val   (a_q),
      .b_val   (b_q),
      .imm     (imm_q),
      .zero_a  (op_q.zero_a),
      .use_imm (op_q.use_imm),
      .shift   (op_q.shift),
      .alu_op  (op_q.alu_op),
      .c_next  (alu_c),
      .flags   (alu_flags)
   );

   always_comb begin
      case (op_q.src)
         SRC_MDATA: wb_data = mdata;
         SRC_IMM:   wb_data = imm_q;
         SRC_PC:    wb_data = WIDTH'(pc);
         default:   wb_data = c_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rn_d     = rn_q;
      rm_d     = rm_q;
      rd_d     = rd_q;
      imm_d    = imm_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      status_d = status_q;
      regs_d   = regs_q;
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               op_d    = '{alu_op: alu_op_e'(alu_op), shift: shift_e'(shift), src: src_e'(src),
                           zero_a: zero_a, use_imm: use_imm, set_flags: set_flags, wr_en: wr_en};
               rn_d    = rn;
               rm_d    = rm;
               rd_d    = rd;
               imm_d   = imm;
               state_d = (src_e'(src) == SRC_C) ? RD_A : WB;
            end
         end
         RD_A: begin
            a_d     = regs_q[rn_q];
            state_d = RD_B;
         end
         RD_B: begin
            b_d     = regs_q[rm_q];
            state_d = EXEC;
         end
         EXEC: begin
            c_d = alu_c;
            if (op_q.set_flags) status_d = alu_flags;
            state_d = WB;
         end
         WB: begin
            if (op_q.wr_en) regs_d[rd_q] = wb_data;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rn_q     <= '0;
         rm_q     <= '0;
         rd_q     <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         status_q <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rn_q     <= rn_d;
         rm_q     <= rm_d;
         rd_q     <= rd_d;
         imm_q    <= imm_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         status_q <= status_d;
         regs_q   <= regs_d;
      end
   end

   // Reset aborts at once, so a WB cycle under reset must not report completion
   assign done      = (state_q == WB) && !reset;
   assign op_ready  = (state_q == IDLE);
   assign result    = c_q;
   assign status    = status_q;
   assign dbg_rdata = regs_q[dbg_rnum];

endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboarded bench for seq_datapath (WIDTH=16, NREGS=8) with an independent signed-arithmetic model.
module tb_seq_datapath;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [1:0]  alu_op = '0, shift = '0, src = '0;
   logic [2:0]  rn = '0, rm = '0, rd = '0, dbg_rnum = '0;
   logic        zero_a = 1'b0, use_imm = 1'b0, set_flags = 1'b0, wr_en = 1'b0;
   logic [15:0] imm = '0;
   logic [15:0] mdata = 16'hA5C3;
   logic [7:0]  pc = 8'h9E;
   logic [15:0] dbg_rdata, result;
   logic [2:0]  status;
   logic        done;

   typedef struct packed {
      logic [15:0] result;
      logic [2:0]  status;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [15:0] model_r [8];
   logic [15:0] c_m;
   logic [2:0]  status_m;
   int          n_tests = 0;
   int          n_fail = 0;
   int          acc_cnt = 0;

   seq_datapath #(.WIDTH(16), .NREGS(8)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .alu_op(alu_op), .shift(shift), .src(src), .rn(rn), .rm(rm), .rd(rd),
      .zero_a(zero_a), .use_imm(use_imm), .set_flags(set_flags), .wr_en(wr_en),
      .imm(imm), .mdata(mdata), .pc(pc), .dbg_rnum(dbg_rnum), .dbg_rdata(dbg_rdata),
      .result(result), .status(status), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   always @(posedge clk) if (!reset && op_valid && op_ready) acc_cnt <= acc_cnt + 1;

   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
         else begin
            mon_e = exp_q.pop_front();
            chk("sb_result", {16'd0, result}, {16'd0, mon_e.result});
            chk("sb_status", {29'd0, status}, {29'd0, mon_e.status});
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) model_r[i] = '0;
      c_m = '0;
      status_m = '0;
   endtask

   task automatic read_reg(input logic [2:0] r, input logic [15:0] expv, input string tag);
      dbg_rnum = r;
      #1;
      chk(tag, {16'd0, dbg_rdata}, {16'd0, expv});
   endtask

   // hold: keep op_valid high (with scrambled fields) while the op is busy
   task automatic run_op(input logic [1:0] aop, input logic [1:0] sh, input logic [1:0] srcv,
                         input logic [2:0] rn_v, input logic [2:0] rm_v, input logic [2:0] rd_v,
                         input logic za, input logic ui, input logic sf, input logic we,
                         input logic [15:0] immv, input logic hold);
      logic [15:0] ain, b, bsh, bin, res, wbv;
      logic        v;
      int          s, lat, exp_lat, acc0;
      exp_t        e;
      if (srcv == 2'b11) begin
         ain = za ? 16'h0000 : model_r[rn_v];
         b   = model_r[rm_v];
         case (sh)
            2'b01:   bsh = {b[14:0], 1'b0};
            2'b10:   bsh = b >> 1;
            2'b11:   bsh = {b[15], b[15:1]};
            default: bsh = b;
         endcase
         bin = ui ? immv : bsh;
         v = 1'b0;
         case (aop)
            2'b00: begin
               s = int'($signed(ain)) + int'($signed(bin));
               res = s[15:0];
               v = (s > 32767) || (s < -32768);
            end
            2'b01: begin
               s = int'($signed(ain)) - int'($signed(bin));
               res = s[15:0];
               v = (s > 32767) || (s < -32768);
            end
            2'b10:   res = ain & bin;
            default: res = ~bin;
         endcase
         c_m = res;
         if (sf) status_m = {v, res[15], res == 16'h0000};
         exp_lat = 4;
      end else exp_lat = 1;
      case (srcv)
         2'b00:   wbv = mdata;
         2'b01:   wbv = immv;
         2'b10:   wbv = {8'h00, pc};
         default: wbv = c_m;
      endcase
      e.result = c_m;
      e.status = status_m;
      exp_q.push_back(e);

      @(negedge clk);
      chk("op_ready_idle", {31'd0, op_ready}, 32'd1);
      acc0 = acc_cnt;
      op_valid = 1'b1; alu_op = aop; shift = sh; src = srcv; rn = rn_v; rm = rm_v; rd = rd_v;
      zero_a = za; use_imm = ui; set_flags = sf; wr_en = we; imm = immv;
      @(posedge clk);
      #1;
      if (hold) begin
         imm = 16'hDEAD; rd = ~rd_v; rn = ~rn_v; alu_op = ~aop; set_flags = ~sf;
      end else op_valid = 1'b0;
      lat = 11;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 3) op_valid = 1'b0;
         if (done) begin
            lat = i;
            break;
         end
      end
      op_valid = 1'b0;
      chk("done_latency", lat, exp_lat);
      if (we) model_r[rd_v] = wbv;
      @(posedge clk);
      #1;
      chk("accept_count", acc_cnt - acc0, 1);
      read_reg(rd_v, model_r[rd_v], "wb_reg");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, op_ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_status", {29'd0, status}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) read_reg(i[2:0], 16'h0000, "rst_reg");

      // 1: immediate writeback
      run_op(2'b00, 2'b00, 2'b01, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0);
      read_reg(3'd2, 16'h0042, "t1_r2");
      chk("t1_status", {29'd0, status}, 32'd0);
      // 2: ADD R2+R0 -> R3
      run_op(2'b00, 2'b00, 2'b11, 3'd2, 3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
      chk("t2_result", {16'd0, result}, 32'h0042);
      read_reg(3'd3, 16'h0042, "t2_r3");
      chk("t2_status", {29'd0, status}, 32'd0);
      // 3: SUB to zero
      run_op(2'b00, 2'b00, 2'b01, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0055, 1'b0);
      run_op(2'b01, 2'b00, 2'b11, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0055, 1'b0);
      chk("t3_result", {16'd0, result}, 32'h0000);
      chk("t3_status", {29'd0, status}, 32'h1);
      // 4: signed overflow, then flags held
      run_op(2'b00, 2'b00, 2'b01, 3'd0, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7F00, 1'b0);
      run_op(2'b00, 2'b00, 2'b11, 3'd6, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b0);
      chk("t4_result", {16'd0, result}, 32'h8000);
      chk("t4_status", {29'd0, status}, 32'h6);
      run_op(2'b01, 2'b00, 2'b11, 3'd6, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("t4_hold_status", {29'd0, status}, 32'h6);
      // 5: shifter variants on B
      run_op(2'b00, 2'b00, 2'b01, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFF9B, 1'b0);
      run_op(2'b00, 2'b11, 2'b11, 3'd0, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("t5_asr", {16'd0, result}, 32'hFFCD);
      run_op(2'b00, 2'b10, 2'b11, 3'd0, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("t5_lsr", {16'd0, result}, 32'h7FCD);
      run_op(2'b00, 2'b01, 2'b11, 3'd0, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("t5_lsl", {16'd0, result}, 32'hFF36);
      // extra patterns: AND, MVN, rd==rn, mdata/pc sources, wr_en=0 writeback
      run_op(2'b10, 2'b00, 2'b11, 3'd5, 3'd6, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
      run_op(2'b11, 2'b00, 2'b11, 3'd0, 3'd4, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
      run_op(2'b01, 2'b00, 2'b11, 3'd3, 3'd1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
      run_op(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
      run_op(2'b00, 2'b00, 2'b10, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
      run_op(2'b00, 2'b00, 2'b01, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0);
      for (int i = 0; i < 8; i++) read_reg(i[2:0], model_r[i], "regfile_sweep");

      // 6: reset during EXEC of a write to R1
      @(negedge clk);
      op_valid = 1'b1; alu_op = 2'b00; shift = 2'b00; src = 2'b11; rn = 3'd0; rm = 3'd0; rd = 3'd1;
      zero_a = 1'b1; use_imm = 1'b1; set_flags = 1'b1; wr_en = 1'b1; imm = 16'h1234;
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_ready_after_rst", {31'd0, op_ready}, 32'd1);
      chk("t6_no_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      chk("t6_no_done_late", {31'd0, done}, 32'd0);
      read_reg(3'd1, 16'h0000, "t6_r1");
      chk("t6_result", {16'd0, result}, 32'd0);
      chk("t6_status", {29'd0, status}, 32'd0);
      // op_valid held while busy, fields scrambled after acceptance
      run_op(2'b00, 2'b00, 2'b11, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0077, 1'b1);
      chk("t6_hold_result", {16'd0, result}, 32'h0077);

      repeat (3) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
